// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: hazard/redirect controls, debug and program-load inputs,
// and the IF/ID register, PC, status and counter outputs.
interface instruction_fetch_if #(
    parameter int IMEM_DEPTH = 256
);
    localparam int ADDR_W = $clog2(IMEM_DEPTH);

    logic              inPC_write;
    logic              inIF_ID_write;
    logic              jump_take;
    logic [31:0]       inAddress_jump;
    logic              inBranch_take;
    logic [31:0]       inAddress_branch;
    logic              stop_debug;
    logic              Debug_step;
    logic              inLoad_en;
    logic [ADDR_W-1:0] inLoad_addr;
    logic [31:0]       inLoad_data;

    logic [31:0]       outInstruction;
    logic [31:0]       outInstructionAddress;
    logic [31:0]       outPC;
    logic              ID_flush;
    logic              outHalt;
    logic [31:0]       outCycle_count;
    logic [31:0]       outFetch_count;

    // Controller side: hazard unit, ID stage and debug unit
    modport master (
        output inPC_write, inIF_ID_write, jump_take, inAddress_jump,
               inBranch_take, inAddress_branch, stop_debug, Debug_step,
               inLoad_en, inLoad_addr, inLoad_data,
        input  outInstruction, outInstructionAddress, outPC, ID_flush,
               outHalt, outCycle_count, outFetch_count
    );

    // Fetch stage side
    modport slave (
        input  inPC_write, inIF_ID_write, jump_take, inAddress_jump,
               inBranch_take, inAddress_branch, stop_debug, Debug_step,
               inLoad_en, inLoad_addr, inLoad_data,
        output outInstruction, outInstructionAddress, outPC, ID_flush,
               outHalt, outCycle_count, outFetch_count
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC, debug-loaded instruction memory, IF/ID
// register, branch/jump redirect with squash, HALT latch, debug freeze and
// single-step, and cycle/fetch counters.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_RUN    | normal fetch; registers move only on advance cycles
// ST_HALTED | HALT_WORD reached IF/ID; PC frozen, IF/ID fed NOPs until reset
module instruction_fetch #(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic clk,
    input  logic rst,
    instruction_fetch_if.slave bus
);
    localparam int ADDR_W = $clog2(IMEM_DEPTH);

    typedef enum logic {ST_RUN, ST_HALTED} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] iaddr_q, iaddr_d;
    logic        flush_q, flush_d;
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] fetch_q, fetch_d;

    logic [31:0] mem_q [IMEM_DEPTH];

    logic        advance;
    logic [31:0] pc_plus4;
    logic [31:0] fetch_word;

    // Halted state blocks advance on its own; debug stop blocks it unless stepping
    assign advance    = (state_q == ST_RUN) && (!bus.stop_debug || bus.Debug_step);
    assign pc_plus4   = pc_q + 32'd4;
    assign fetch_word = mem_q[pc_q[ADDR_W+1:2]];

    // Program load port, only honoured while the pipeline is frozen by debug
    always_ff @(posedge clk) begin
        if (bus.inLoad_en && bus.stop_debug) begin
            mem_q[bus.inLoad_addr] <= bus.inLoad_data;
        end
    end

    // State, PC, IF/ID, flush and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
            instr_q <= '0;
            iaddr_q <= '0;
            flush_q <= 1'b0;
            cycle_q <= '0;
            fetch_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            iaddr_q <= iaddr_d;
            flush_q <= flush_d;
            cycle_q <= cycle_d;
            fetch_q <= fetch_d;
        end
    end

    // Next-state: redirect priority branch > jump > sequential fetch
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        iaddr_d = iaddr_q;
        flush_d = flush_q;
        cycle_d = cycle_q;
        fetch_d = fetch_q;

        case (state_q)
            ST_RUN: begin
                if (advance) begin
                    cycle_d = cycle_q + 32'd1;
                    flush_d = 1'b0;
                    if (bus.inBranch_take) begin
                        pc_d    = bus.inAddress_branch;
                        instr_d = '0;
                        iaddr_d = '0;
                        flush_d = 1'b1;
                    end else if (bus.jump_take) begin
                        pc_d    = bus.inAddress_jump;
                        instr_d = '0;
                        iaddr_d = '0;
                    end else begin
                        if (bus.inPC_write) begin
                            pc_d = pc_plus4;
                        end
                        if (bus.inIF_ID_write) begin
                            instr_d = fetch_word;
                            iaddr_d = pc_plus4;
                            fetch_d = fetch_q + 32'd1;
                            // A squashed HALT never gets here, so it cannot halt
                            if (fetch_word == HALT_WORD) begin
                                state_d = ST_HALTED;
                            end
                        end
                    end
                end
            end
            ST_HALTED: begin
                instr_d = '0;
                iaddr_d = '0;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign bus.outInstruction        = instr_q;
    assign bus.outInstructionAddress = iaddr_q;
    assign bus.outPC                 = pc_q;
    assign bus.ID_flush              = flush_q;
    assign bus.outHalt               = (state_q == ST_HALTED);
    assign bus.outCycle_count        = cycle_q;
    assign bus.outFetch_count        = fetch_q;
endmodule
